// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor.
//   state_t        : FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH  : default operand / result width
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor: computes x - y - bin.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// Purely combinational.
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // A borrow leaves this bit when y exceeds x outright, or when the two
  // are equal and a borrow arrived from below.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit/clock.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : launch request, sampled only while idle
//   a, b   : operands, captured on the accepting edge
//   busy   : high during RUN and DONE
//   done   : one-cycle pulse when diff/borrow have just been updated
//   diff   : registered result, modulo 2^WIDTH
//   borrow : registered final borrow (a < b, unsigned)
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  // Only WIDTH-1 result bits need storing: the final bit comes straight
  // from the subtractor cell on the last RUN edge.
  logic [WIDTH-2:0] sd_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] sd_cat;
  logic             last_bit;

  full_subtractor u_fs (
    .x    (sa_reg[0]),
    .y    (sb_reg[0]),
    .bin  (br_reg),
    .d    (d_bit),
    .bout (br_next)
  );

  // New bit enters at the MSB; after the last step sd_cat is the full result.
  assign sd_cat   = {d_bit, sd_reg};
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      sd_reg     <= '0;
      cnt_reg    <= '0;
      br_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa_reg <= sa_reg >> 1;
          sb_reg <= sb_reg >> 1;
          sd_reg <= sd_cat[WIDTH-1:1];
          br_reg <= br_next;
          if (last_bit) begin
            // Result registers load on this edge so they are already valid
            // during the DONE cycle, alongside the done pulse.
            diff_reg   <= sd_cat;
            borrow_reg <= br_next;
            done_reg   <= 1'b1;
            state_reg  <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign diff   = diff_reg;
  assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH = 8).
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Launches one operation from an idle cycle and waits for done.
  // Returns the captured result, cycles from accept edge to done,
  // busy-high cycles seen, and whether diff/borrow held steady in RUN.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit hold,
                       output logic [W-1:0] rd, output logic rb,
                       output int lat, output int bcnt, output bit held);
    logic [W-1:0] pd;
    logic         pb;
    bit           fin;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    pd = diff;
    pb = borrow;
    held = 1'b1;
    start = 1'b1;
    a = ta;
    b = tb;
    @(posedge clk);
    lat = 0;
    bcnt = 0;
    fin = 1'b0;
    rd = '0;
    rb = 1'b0;
    while (!fin) begin
      @(negedge clk);
      lat++;
      if (hold) begin
        a = 8'h11;
        b = 8'h22;
      end else begin
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
      end
      if (busy) bcnt++;
      if (done) begin
        rd = diff;
        rb = borrow;
        fin = 1'b1;
      end else begin
        if (diff !== pd || borrow !== pb) held = 1'b0;
        if (lat > 40) begin
          check("done_timeout", 32'(lat), 32'(W + 1));
          fin = 1'b1;
        end
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input bit hold, input logic [W-1:0] ed, input logic eb);
    logic [W-1:0] rd;
    logic         rb;
    int           lat;
    int           bcnt;
    bit           held;
    do_op(ta, tb, hold, rd, rb, lat, bcnt, held);
    $display("%s a=%02h b=%02h diff=%02h borrow=%0d exp=%02h/%0d lat=%0d",
             tag, ta, tb, rd, rb, ed, eb, lat);
    check({tag, "_diff"}, 32'(rd), 32'(ed));
    check({tag, "_borrow"}, 32'(rb), 32'(eb));
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(W + 1));
    check({tag, "_result_held"}, 32'(held), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, diff: 8'h1E, borrow: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'hFF, diff: 8'h01, borrow: 1'b1};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, borrow: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'h00, diff: 8'hFF, borrow: 1'b0};
    vecs[5] = '{a: 8'h01, b: 8'h80, diff: 8'h81, borrow: 1'b1};

    // Reset state, with start asserted under reset too.
    #2;
    start = 1'b1;
    #10;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0, vecs[i].diff, vecs[i].borrow);
    end

    // start held high with operands changing during busy: one result only,
    // then the held start launches 0x11 - 0x22 once busy has fallen.
    run_check("hold", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0);
    run_check("hold_next", 8'h11, 8'h22, 1'b0, 8'hEF, 1'b1);

    // Reset in the middle of RUN.
    begin
      bit saw_done;
      @(negedge clk);
      start = 1'b1;
      a = 8'h40;
      b = 8'h20;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      $display("midrst busy=%0d done=%0d diff=%02h borrow=%0d", busy, done, diff, borrow);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_diff", 32'(diff), 32'd0);
      check("midrst_borrow", 32'(borrow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      check("midrst_no_done", 32'(saw_done), 32'd0);
      run_check("after_rst", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    end

    // Randomised back-to-back operations against a plain arithmetic model.
    for (int n = 0; n < 1000; n++) begin
      int ra;
      int rb_i;
      logic [W-1:0] ed;
      logic         eb;
      ra   = int'($urandom_range(0, (1 << W) - 1));
      rb_i = int'($urandom_range(0, (1 << W) - 1));
      ed   = W'((ra - rb_i + (1 << W)) % (1 << W));
      eb   = (ra < rb_i);
      run_check($sformatf("rnd%0d", n), W'(ra), W'(rb_i), 1'b0, ed, eb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes diff = a - b, LSB first, one bit per clock.
- Built around a single full-subtractor cell plus a borrow flip-flop.
- This is the subtract counterpart to the team's adder blocks, for area-constrained datapaths.
- Start/busy/done handshake: a controller launches an operation and collects diff and borrow when done pulses.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock; the block's only clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a subtraction; sampled only in IDLE
a  input  WIDTH  minuend; sampled in the cycle start is accepted
b  input  WIDTH  subtrahend; sampled in the cycle start is accepted
busy  output  1  high in RUN and DONE; start is ignored while high
done  output  1  one-cycle pulse when diff/borrow are updated
diff  output  WIDTH  registered result a - b, modulo 2^WIDTH
borrow  output  1  registered final borrow; 1 when a < b (unsigned)

Behaviour:
- Reset, asynchronous and active-high:
  - state = IDLE.
  - Shift registers, bit counter and borrow flop cleared.
  - busy = 0, done = 0, diff = 0, borrow = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start = 1.
  - RUN -> DONE when counter = WIDTH-1 at the clock edge.
  - DONE -> IDLE unconditionally after one cycle.
- Accepting start (IDLE and start = 1):
  - a and b are loaded into shift registers sa and sb.
  - The borrow flop and counter are cleared.
  - The accepting edge moves state to RUN.
- Each RUN cycle:
  - d = sa[0] ^ sb[0] ^ br.
  - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - sa and sb shift right by one.
  - The internal result shift register sd shifts right with d inserted at the MSB.
  - The counter increments.
- The last RUN edge (counter = WIDTH-1):
  - Writes the final bit into sd and br_next into the borrow flop.
  - Moves state to DONE.
- DONE cycle:
  - diff <= sd and borrow <= br, visible in the same cycle that done = 1.
  - done is a registered pulse asserted only in the DONE state.
- Latency: start sampled at edge k -> done high during the cycle after edge k+WIDTH. This gives exactly WIDTH RUN cycles and one DONE cycle, for WIDTH+1 cycles of busy.
- diff/borrow hold their value until the next DONE. They do not change during RUN, so the controller may read the previous result while a new operation runs.
- Minimum start-to-start spacing is WIDTH+2 cycles. start may be re-asserted in the first cycle busy is low.
- Boundary conditions:
  - start during RUN or DONE: ignored entirely; no reload and no restart.
  - a, b changing after acceptance: no effect (latched copies are used).
  - a == b: diff = 0, borrow = 0.
  - a = 0, b = 2^WIDTH-1: diff = 1, borrow = 1 (wrap-around).
  - rst asserted mid-RUN: operation aborted immediately; all outputs 0; no done pulse. After rst deasserts, the next start begins a fresh operation.
  - rst and start in the same cycle: rst wins.
- Counter width is clog2(WIDTH). Counter never exceeds WIDTH-1.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - default WIDTH = 8.
- Sub-module full_subtractor, purely combinational:
  - inputs x, y, bin; outputs d, bout;
  - instantiated once for the per-bit stage;
  - reusable elsewhere in the codebase.
- Top level holds the FSM, shift registers, counter, borrow flop and output registers.

Test Plan:
- Basic, no borrow: WIDTH=8, a=0x5A, b=0x3C, start for 1 cycle -> done at cycle 9 after the accepting edge; diff=0x1E, borrow=0; busy high for 9 cycles.
- Wrap-around: a=0x00, b=0x01 -> diff=0xFF, borrow=1. Then a=0x00, b=0xFF -> diff=0x01, borrow=1.
- Equal and extreme operands: a=0xFF, b=0xFF -> diff=0x00, borrow=0. Also a=0xFF, b=0x00 -> diff=0xFF, borrow=0.
- start held high and operands changed during RUN: a=0x80, b=0x01, then start kept high with a=0x11, b=0x22 driven during busy -> a single done with diff=0x7F, borrow=0; the next operation starts only once busy falls.
- Reset mid-operation: start a=0x40, b=0x20, assert rst at RUN cycle 4 -> busy, done, diff, borrow all 0 immediately and no done pulse. A new start with a=0x03, b=0x05 then yields diff=0xFE, borrow=1.
- Randomised back-to-back: 1000 random a/b pairs, each start issued the first cycle busy is low -> every done matches {borrow, diff} = {a < b, (a - b) mod 256}; diff holds steady during the following RUN.
